// File: rtl/bus_split_pkg.sv
// Shared types and defaults for the 1:2 memory request splitter (RAM / MMIO).
package bus_split_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ERR   = 2'd3
   } state_t;

   localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;
   localparam logic [31:0] MMIO_SIZE_DEF = 32'h0001_0000;

   localparam logic TARGET_A = 1'b0;
   localparam logic TARGET_B = 1'b1;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational MMIO window compare and word-alignment check.
module bus_addr_decode
   import bus_split_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
   parameter logic [31:0] MMIO_SIZE = MMIO_SIZE_DEF
)(
   input  logic [31:0] addr,
   output logic        hit_b,
   output logic        misaligned
);

   // Subtraction is only meaningful once addr >= base, so no wrap is possible.
   assign hit_b      = (addr >= MMIO_BASE) && ((addr - MMIO_BASE) < MMIO_SIZE);
   assign misaligned = (addr[1:0] != 2'b00);

endmodule

// File: rtl/bus_split_1to2.sv
// Routes one request stream to RAM (A) or MMIO (B); one outstanding transaction.
// Optional watchdog on ISSUE/WAIT enabled by defining BUS_SPLIT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a new request
// ISSUE | selected target request valid, waiting for its ready
// WAIT  | waiting for the selected target response
// ERR   | error response pulse (misaligned or watchdog expiry)
module bus_split_1to2
   import bus_split_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEF,
   parameter logic [31:0] MMIO_SIZE      = MMIO_SIZE_DEF,
   parameter int          TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_byte_en,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        a_req_valid,
   input  logic        a_req_ready,
   output logic        a_req_write,
   output logic [31:0] a_req_addr,
   output logic [31:0] a_req_wdata,
   output logic [3:0]  a_req_byte_en,
   input  logic        a_rsp_valid,
   input  logic [31:0] a_rsp_rdata,
   output logic        b_req_valid,
   input  logic        b_req_ready,
   output logic        b_req_write,
   output logic [31:0] b_req_addr,
   output logic [31:0] b_req_wdata,
   output logic [3:0]  b_req_byte_en,
   input  logic        b_rsp_valid,
   input  logic [31:0] b_rsp_rdata
);

   state_t      state_q, state_d;
   logic        cap_write_q, cap_write_d;
   logic [31:0] cap_addr_q, cap_addr_d;
   logic [31:0] cap_wdata_q, cap_wdata_d;
   logic [3:0]  cap_be_q, cap_be_d;
   logic        sel_q, sel_d;

   logic        hit_b, misaligned;
   logic        accept, issue_done, rsp_seen, rsp_take, timeout;
   logic        a_valid_d, b_valid_d, rsp_valid_d, req_ready_d;
   logic [31:0] rsp_rdata_d;

   bus_addr_decode #(
      .MMIO_BASE (MMIO_BASE),
      .MMIO_SIZE (MMIO_SIZE)
   ) u_dec (
      .addr       (req_addr),
      .hit_b      (hit_b),
      .misaligned (misaligned)
   );

   assign accept     = (state_q == IDLE) && req_ready && req_valid;
   assign issue_done = (sel_q == TARGET_B) ? b_req_ready : a_req_ready;
   assign rsp_seen   = (sel_q == TARGET_B) ? b_rsp_valid : a_rsp_valid;
   assign rsp_take   = (state_q == WAIT) && rsp_seen;

`ifdef BUS_SPLIT_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TMO_W-1:0] tmo_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else if (accept && !misaligned) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
         tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end
   end

   assign timeout = ((state_q == ISSUE) || (state_q == WAIT)) &&
                    (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cap_write_d = cap_write_q;
      cap_addr_d  = cap_addr_q;
      cap_wdata_d = cap_wdata_q;
      cap_be_d    = cap_be_q;
      sel_d       = sel_q;
      if (accept) begin
         cap_write_d = req_write;
         cap_addr_d  = req_addr;
         cap_wdata_d = req_wdata;
         cap_be_d    = req_byte_en;
         sel_d       = hit_b ? TARGET_B : TARGET_A;
      end
      case (state_q)
         IDLE:  if (accept) state_d = misaligned ? ERR : ISSUE;
         // A target that has already taken the request wins over the watchdog.
         ISSUE: if (issue_done) state_d = WAIT;
                else if (timeout) state_d = ERR;
         WAIT:  if (rsp_seen) state_d = IDLE;
                else if (timeout) state_d = ERR;
         ERR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      a_valid_d   = (state_d == ISSUE) && (sel_d == TARGET_A);
      b_valid_d   = (state_d == ISSUE) && (sel_d == TARGET_B);
      rsp_valid_d = (state_d == ERR) || rsp_take;
      rsp_rdata_d = '0;
      if (rsp_take && !cap_write_q) begin
         rsp_rdata_d = (sel_q == TARGET_B) ? b_rsp_rdata : a_rsp_rdata;
      end
      req_ready_d = (state_d == IDLE) && !rsp_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cap_write_q   <= 1'b0;
         cap_addr_q    <= '0;
         cap_wdata_q   <= '0;
         cap_be_q      <= '0;
         sel_q         <= TARGET_A;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         a_req_valid   <= 1'b0;
         a_req_write   <= 1'b0;
         a_req_addr    <= '0;
         a_req_wdata   <= '0;
         a_req_byte_en <= '0;
         b_req_valid   <= 1'b0;
         b_req_write   <= 1'b0;
         b_req_addr    <= '0;
         b_req_wdata   <= '0;
         b_req_byte_en <= '0;
      end else begin
         state_q       <= state_d;
         cap_write_q   <= cap_write_d;
         cap_addr_q    <= cap_addr_d;
         cap_wdata_q   <= cap_wdata_d;
         cap_be_q      <= cap_be_d;
         sel_q         <= sel_d;
         req_ready     <= req_ready_d;
         rsp_valid     <= rsp_valid_d;
         rsp_rdata     <= rsp_rdata_d;
         rsp_err       <= (state_d == ERR);
         a_req_valid   <= a_valid_d;
         a_req_write   <= a_valid_d & cap_write_d;
         a_req_addr    <= a_valid_d ? cap_addr_d  : '0;
         a_req_wdata   <= a_valid_d ? cap_wdata_d : '0;
         a_req_byte_en <= a_valid_d ? cap_be_d    : '0;
         b_req_valid   <= b_valid_d;
         b_req_write   <= b_valid_d & cap_write_d;
         b_req_addr    <= b_valid_d ? cap_addr_d  : '0;
         b_req_wdata   <= b_valid_d ? cap_wdata_d : '0;
         b_req_byte_en <= b_valid_d ? cap_be_d    : '0;
      end
   end

endmodule

// File: tb/tb_bus_split_1to2.sv
// Self-checking bench for bus_split_1to2: scoreboard of expected responses
// (data, error flag, exact arrival cycle) popped by a negedge monitor.
module tb_bus_split_1to2;

`ifdef BUS_SPLIT_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_byte_en;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid;
   logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic [3:0]  a_req_byte_en;
   logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
   logic [3:0]  b_req_byte_en;

   bus_split_1to2 #(
      .MMIO_BASE      (32'hFFFF_0000),
      .MMIO_SIZE      (32'h0001_0000),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
      .req_addr (req_addr), .req_wdata (req_wdata), .req_byte_en (req_byte_en),
      .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
      .a_req_valid (a_req_valid), .a_req_ready (a_req_ready), .a_req_write (a_req_write),
      .a_req_addr (a_req_addr), .a_req_wdata (a_req_wdata), .a_req_byte_en (a_req_byte_en),
      .a_rsp_valid (a_rsp_valid), .a_rsp_rdata (a_rsp_rdata),
      .b_req_valid (b_req_valid), .b_req_ready (b_req_ready), .b_req_write (b_req_write),
      .b_req_addr (b_req_addr), .b_req_wdata (b_req_wdata), .b_req_byte_en (b_req_byte_en),
      .b_rsp_valid (b_rsp_valid), .b_rsp_rdata (b_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ncyc     = 0;
   logic both_seen = 1'b0;

   logic out_any, a_any, b_any;
   assign a_any   = |{a_req_valid, a_req_write, a_req_addr, a_req_wdata, a_req_byte_en};
   assign b_any   = |{b_req_valid, b_req_write, b_req_addr, b_req_wdata, b_req_byte_en};
   assign out_any = |{req_ready, rsp_valid, rsp_rdata, rsp_err, a_any, b_any};

   always @(negedge clk) begin
      exp_t e;
      ncyc = ncyc + 1;
      if (a_req_valid && b_req_valid) both_seen = 1'b1;
      if (rst_n && rsp_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL stray_rsp: rsp_valid=1 rdata=%h err=%b at cyc %0d, required no response",
                     rsp_rdata, rsp_err, ncyc);
         end else begin
            e = sb.pop_front();
            if ({rsp_rdata, rsp_err} !== {e.rdata, e.err} || ncyc != e.at) begin
               n_fail++;
               $display("FAIL rsp: got rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                        rsp_rdata, rsp_err, ncyc, e.rdata, e.err, e.at);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue_req(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, output int acc);
      int g = 0;
      @(negedge clk);
      while (!req_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL req_ready_wait: req_ready=%b after %0d cycles, required 1", req_ready, g);
      end
      req_valid   = 1'b1;
      req_write   = w;
      req_addr    = addr;
      req_wdata   = wd;
      req_byte_en = be;
      @(posedge clk);
      acc = ncyc;
      #1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      req_byte_en = '0;
   endtask

   task automatic wait_drain(input string name);
      int g = 0;
      while ((sb.size() != 0 || !req_ready) && g < 40) begin
         @(negedge clk);
         #1;
         g++;
      end
      n_checks++;
      if (sb.size() != 0 || !req_ready) begin
         n_fail++;
         $display("FAIL %s_drain: pending=%0d req_ready=%b, required 0 and 1", name, sb.size(), req_ready);
         sb.delete();
         a_rsp_valid = 1'b0;
         b_rsp_valid = 1'b0;
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_byte_en = '0;
      a_req_ready = 0; a_rsp_valid = 0; a_rsp_rdata = '0;
      b_req_ready = 0; b_rsp_valid = 0; b_rsp_rdata = '0;
      #12;
      n_checks++;
      if (out_any !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: some output nonzero (%b), required all 0", out_any);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
      end
   endtask

   task automatic test_load_a();
      int acc;
      a_req_ready = 1'b1;
      issue_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, acc);
      sb.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, at: acc + 3});
      @(negedge clk);
      n_checks++;
      if ({a_req_valid, a_req_write, a_req_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
         n_fail++;
         $display("FAIL load_a_issue: valid=%b write=%b addr=%h, required 1 0 00001000",
                  a_req_valid, a_req_write, a_req_addr);
      end
      n_checks++;
      if ({b_any, req_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL load_a_bquiet: b_any=%b req_ready=%b, required 0 0", b_any, req_ready);
      end
      @(negedge clk);
      n_checks++;
      if (a_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL load_a_drop: a_req_valid=%b, required 0", a_req_valid);
      end
      a_rsp_valid = 1'b1;
      a_rsp_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      a_rsp_valid = 1'b0;
      a_rsp_rdata = '0;
      n_checks++;
      if ({req_ready, b_any} !== 2'b00) begin
         n_fail++;
         $display("FAIL load_a_rspcycle: req_ready=%b b_any=%b, required 0 0", req_ready, b_any);
      end
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL load_a_ready_back: req_ready=%b, required 1", req_ready);
      end
      wait_drain("load_a");
   endtask

   task automatic test_store_b_stall();
      int acc;
      b_req_ready = 1'b0;
      issue_req(1'b1, 32'hFFFF_0010, 32'h1234_5678, 4'hF, acc);
      sb.push_back('{rdata: 32'h0, err: 1'b0, at: acc + 8});
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         n_checks++;
         if ({b_req_valid, b_req_write, b_req_addr, b_req_wdata, b_req_byte_en} !==
             {1'b1, 1'b1, 32'hFFFF_0010, 32'h1234_5678, 4'hF}) begin
            n_fail++;
            $display("FAIL store_b_hold[%0d]: v=%b w=%b addr=%h data=%h be=%h, required 1 1 ffff0010 12345678 f",
                     i, b_req_valid, b_req_write, b_req_addr, b_req_wdata, b_req_byte_en);
         end
         n_checks++;
         if ({a_any, req_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL store_b_quiet[%0d]: a_any=%b req_ready=%b, required 0 0", i, a_any, req_ready);
         end
         if (i == 6) b_req_ready = 1'b1;
      end
      @(negedge clk);
      b_req_ready = 1'b0;
      n_checks++;
      if (b_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL store_b_drop: b_req_valid=%b, required 0", b_req_valid);
      end
      b_rsp_valid = 1'b1;
      b_rsp_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      b_rsp_valid = 1'b0;
      b_rsp_rdata = '0;
      wait_drain("store_b");
   endtask

   task automatic test_boundary();
      logic [31:0] addrs [4];
      logic        is_b  [4];
      int          acc;
      addrs = '{32'hFFFE_FFFC, 32'hFFFF_0000, 32'hFFFF_FFFC, 32'h0000_0000};
      is_b  = '{1'b0, 1'b1, 1'b1, 1'b0};
      a_req_ready = 1'b1;
      b_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue_req(1'b0, addrs[i], 32'h0, 4'h0, acc);
         sb.push_back('{rdata: addrs[i] ^ 32'h5A5A_5A5A, err: 1'b0, at: acc + 3});
         @(negedge clk);
         n_checks++;
         if ({a_req_valid, b_req_valid} !== (is_b[i] ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL boundary_route[%h]: a_valid=%b b_valid=%b, required target %s",
                     addrs[i], a_req_valid, b_req_valid, is_b[i] ? "B" : "A");
         end
         @(negedge clk);
         if (is_b[i]) begin
            b_rsp_valid = 1'b1;
            b_rsp_rdata = addrs[i] ^ 32'h5A5A_5A5A;
         end else begin
            a_rsp_valid = 1'b1;
            a_rsp_rdata = addrs[i] ^ 32'h5A5A_5A5A;
         end
         @(negedge clk);
         a_rsp_valid = 1'b0;
         b_rsp_valid = 1'b0;
         a_rsp_rdata = '0;
         b_rsp_rdata = '0;
         wait_drain("boundary");
      end
      b_req_ready = 1'b0;
   endtask

   task automatic test_misaligned();
      int acc;
      a_req_ready = 1'b1;
      issue_req(1'b0, 32'h0000_1002, 32'h0, 4'h0, acc);
      sb.push_back('{rdata: 32'h0, err: 1'b1, at: acc + 1});
      @(negedge clk);
      n_checks++;
      if ({a_req_valid, b_req_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL misaligned_fwd: a_valid=%b b_valid=%b, required 0 0", a_req_valid, b_req_valid);
      end
      @(negedge clk);
      n_checks++;
      if ({req_ready, a_req_valid, b_req_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL misaligned_after: req_ready=%b a_valid=%b b_valid=%b, required 1 0 0",
                  req_ready, a_req_valid, b_req_valid);
      end
      wait_drain("misaligned");
   endtask

   task automatic test_stray();
      int acc;
      a_req_ready = 1'b1;
      b_req_ready = 1'b0;
      @(negedge clk);
      b_rsp_valid = 1'b1;
      b_rsp_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      b_rsp_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL stray_idle: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
      end
      issue_req(1'b0, 32'h0000_2000, 32'h0, 4'h0, acc);
      sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, at: acc + 4});
      @(negedge clk);
      b_rsp_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      b_rsp_valid = 1'b0;
      b_rsp_rdata = '0;
      a_rsp_valid = 1'b1;
      a_rsp_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      a_rsp_valid = 1'b0;
      a_rsp_rdata = '0;
      wait_drain("stray");
   endtask

   task automatic test_back_to_back();
      int acc, prev;
      prev = 0;
      a_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue_req(1'b0, 32'h0000_3000 + 32'(i * 4), 32'h0, 4'h0, acc);
         if (i > 0) begin
            n_checks++;
            if (acc - prev != 4) begin
               n_fail++;
               $display("FAIL b2b_spacing[%0d]: %0d cycles between accepts, required 4", i, acc - prev);
            end
         end
         prev = acc;
         sb.push_back('{rdata: 32'h1111_0000 + 32'(i), err: 1'b0, at: acc + 3});
         @(negedge clk);
         @(negedge clk);
         a_rsp_valid = 1'b1;
         a_rsp_rdata = 32'h1111_0000 + 32'(i);
         @(negedge clk);
         a_rsp_valid = 1'b0;
         a_rsp_rdata = '0;
      end
      wait_drain("b2b");
   endtask

   task automatic test_reset_mid();
      int acc;
      a_req_ready = 1'b1;
      issue_req(1'b0, 32'h0000_4000, 32'h0, 4'h0, acc);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_any !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_async: some output nonzero (%b), required all 0", out_any);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_mid_release: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
      end
      repeat (3) @(negedge clk);
      wait_drain("reset_mid");
   endtask

`ifdef BUS_SPLIT_TIMEOUT_EN
   task automatic test_timeout();
      int acc;
      a_req_ready = 1'b1;
      issue_req(1'b0, 32'h0000_5000, 32'h0, 4'h0, acc);
      sb.push_back('{rdata: 32'h0, err: 1'b1, at: acc + TMO + 1});
      repeat (TMO + 3) @(negedge clk);
      a_rsp_valid = 1'b1;
      a_rsp_rdata = 32'h7777_7777;
      @(negedge clk);
      a_rsp_valid = 1'b0;
      a_rsp_rdata = '0;
      wait_drain("timeout");
   endtask
`endif

   task automatic test_exclusive();
      n_checks++;
      if (both_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL exclusive: a_req_valid and b_req_valid seen together=%b, required 0", both_seen);
      end
   endtask

   initial begin
      test_reset();
      test_load_a();
      test_store_b_stall();
      test_boundary();
      test_misaligned();
      test_stray();
      test_back_to_back();
      test_reset_mid();
`ifdef BUS_SPLIT_TIMEOUT_EN
      test_timeout();
`endif
      test_exclusive();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_split_1to2.md
Name: bus_split_1to2

Overview:
- Routes one CPU-side memory request stream to one of two targets: A = data RAM, B = MMIO peripheral window.
- It is the distributing counterpart of the datapath's 2:1 selectors: one producer fans out to two consumers, and the response is steered back.
- Sits between the MEM stage load/store unit and the RAM / MMIO slaves.
- One outstanding transaction; all outputs are registered.

Parameters:
- MMIO_BASE, 32'hFFFF_0000, first byte address of target B window.
- MMIO_SIZE, 32'h0001_0000, window size in bytes; nonzero.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles. Used only with BUS_SPLIT_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  1  upstream request valid.
- ReqReady  out  1  upstream request accepted when ReqValid&ReqReady.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data.
- ReqByteEn  in  4  store byte lanes.
- RspValid  out  1  one-cycle response pulse to upstream.
- RspRData  out  32  load data, valid with RspValid.
- RspErr  out  1  error flag, valid with RspValid.
- AReqValid / BReqValid  out  1  downstream request valid.
- AReqReady / BReqReady  in  1  downstream accept.
- AReqWrite / BReqWrite  out  1  forwarded ReqWrite.
- AReqAddr / BReqAddr  out  32  forwarded address.
- AReqWData / BReqWData  out  32  forwarded store data.
- AReqByteEn / BReqByteEn  out  4  forwarded byte enables.
- ARspValid / BRspValid  in  1  downstream response pulse; writes also respond.
- ARspRData / BRspRData  in  32  downstream load data.

Behaviour:
- Reset (async, Rst_n=0): state IDLE.
  - All outputs 0.
  - Captured request registers 0.
  - Sel = A.
- Decode: hit B iff ReqAddr >= MMIO_BASE and (ReqAddr - MMIO_BASE) < MMIO_SIZE, as 32-bit unsigned compares with no overflow wrap; otherwise A.
- Misaligned request = ReqAddr[1:0] != 0.
- States: IDLE, ISSUE, WAIT, ERR.
- IDLE: ReqReady = 1.
  - On ReqValid: capture Write/Addr/WData/ByteEn and Sel.
  - If misaligned → ERR; else → ISSUE.
- ISSUE: ReqReady = 0.
  - Selected XReqValid = 1 with captured fields held stable; the unselected port's valid = 0, and its other outputs are 0.
  - On XReqReady → WAIT; XReqValid drops the next cycle.
- WAIT: on the selected XRspValid, register the data.
  - Next cycle: RspValid = 1, RspRData = data (0 for writes), RspErr = 0, state IDLE.
- ERR: RspValid = 1, RspErr = 1, RspRData = 0 for one cycle → IDLE. Nothing is forwarded downstream.
- Latency:
  - Request accepted at cycle t; XReqValid asserted at t+1.
  - Response at c+1, where c is the cycle XRspValid is seen.
  - Minimum accept-to-RspValid is 3 cycles (t+3), with ready and response each taking one cycle.
- ReqReady is low from the cycle after acceptance until the cycle after RspValid.
  - The back-to-back minimum is one request every 4 cycles.
- Stray response (unselected XRspValid, or any XRspValid in IDLE/ISSUE/ERR) is ignored with no side effect.
- A and B are never valid simultaneously.
- Reset mid-transaction: immediate return to IDLE and outputs 0. No response is generated for the aborted request.

Optional Feature:
- BUS_SPLIT_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to ISSUE and counts each cycle spent in ISSUE or WAIT.
  - On reaching TIMEOUT_CYCLES: XReqValid drops, state → ERR (RspErr=1), and any late response is ignored as stray.
- Undefined: no counter is present; ISSUE/WAIT wait indefinitely. RspErr is set only for misalignment.

Decomposition:
- Shared package bus_split_pkg holds:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ERR=2'd3);
  - defaults for MMIO_BASE/MMIO_SIZE;
  - the TARGET_A=1'b0, TARGET_B=1'b1 constants.
- One sub-module, bus_addr_decode: combinational address-window compare and misalignment check. Its outputs are HitB and Misaligned.

Test Plan:
- Load 0x0000_1000, AReqReady=1, ARspRData=0xDEADBEEF one cycle after accept → AReqValid at t+1; RspValid=1, RspRData=0xDEADBEEF, RspErr=0 at t+3; B ports stay 0.
- Store 0xFFFF_0010 data 0x12345678 ByteEn 4'hF, BReqReady held 0 for 5 cycles → BReqValid held with stable fields for 6 cycles; ReqReady=0 throughout; RspValid after BRspValid.
- Boundary: 0xFFFE_FFFC → A; 0xFFFF_0000 → B; 0xFFFF_FFFC → B (with MMIO_SIZE=0x10000).
- Misaligned load 0x0000_1002 → no downstream valid; RspValid=1, RspErr=1, RspRData=0 at t+1.
- Stray BRspValid during an A transaction, and in IDLE → ignored; A response is delivered correctly.
- Rst_n pulsed low in WAIT → all outputs 0 asynchronously, ReqReady=1 after release, no RspValid. With BUS_SPLIT_TIMEOUT_EN and TIMEOUT_CYCLES=8, A never responds → RspErr=1 after 8 cycles.
